// File: rtl/toggle_rate_if.sv
// Control/status bundle between a ramp-profile requester and toggle_rate_sequencer.
// The master drives the request and configuration; the slave returns rate and status.
interface toggle_rate_if #(
  parameter int DWELL_W = 16
);
  logic               start;
  logic               abort;
  logic [6:0]         target_rate;
  logic [6:0]         step;
  logic [DWELL_W-1:0] dwell;
  logic [DWELL_W-1:0] hold_cycles;
  logic [6:0]         toggle_rate;
  logic               busy;
  logic               done;
  logic [2:0]         state;

  modport master (
    output start, abort, target_rate, step, dwell, hold_cycles,
    input  toggle_rate, busy, done, state
  );

  modport slave (
    input  start, abort, target_rate, step, dwell, hold_cycles,
    output toggle_rate, busy, done, state
  );
endinterface

// File: rtl/toggle_rate_sequencer.sv
// Ramps toggle_rate up to a target, holds it, ramps back to zero and pulses done.
// Optional macro TOGGLE_SEQ_LOOP_EN: repeat the latched profile until abort or rst.
module toggle_rate_sequencer #(
  parameter int DWELL_W  = 16,
  parameter int MAX_RATE = 100
) (
  input  logic          clk,
  input  logic          rst,
  toggle_rate_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    HOLD      = 3'd2,
    RAMP_DOWN = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam logic [6:0]         RATE_CEIL = 7'(MAX_RATE);
  localparam logic [DWELL_W-1:0] CNT_ONE   = DWELL_W'(1);

  state_t             st;
  logic [6:0]         rate;
  logic [6:0]         target_l;
  logic [6:0]         step_l;
  logic [DWELL_W-1:0] dwell_l;
  logic [DWELL_W-1:0] hold_l;
  logic [DWELL_W-1:0] cnt;
  logic               busy_r;
  logic               done_r;
  logic               pend;   // config latched, RAMP_UP starts on the next edge

  // Eight bits so rate + step cannot wrap before the comparison with target.
  logic [7:0] sum_up;
  logic [6:0] rate_dn;

  assign sum_up  = {1'b0, rate} + {1'b0, step_l};
  assign rate_dn = (rate > step_l) ? rate - step_l : 7'd0;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registers here use non-blocking assignments so every branch sees the
    // pre-edge values of rate/cnt/st; blocking would chain updates within one edge.
    if (rst) begin
      // NOTE: the latched configuration is a handful of flops, not a memory, so it
      // is cleared with everything else to leave no stale profile behind.
      st       <= IDLE;
      rate     <= '0;
      target_l <= '0;
      step_l   <= '0;
      dwell_l  <= '0;
      hold_l   <= '0;
      cnt      <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      pend     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (bus.abort) begin
        st     <= IDLE;
        rate   <= '0;
        cnt    <= '0;
        busy_r <= 1'b0;
        pend   <= 1'b0;
      end else begin
        case (st)
          IDLE: begin
            rate   <= '0;
            busy_r <= 1'b0;
            if (pend) begin
              pend   <= 1'b0;
              st     <= RAMP_UP;
              cnt    <= dwell_l - CNT_ONE;
              busy_r <= 1'b1;
            end else if (bus.start) begin
              pend     <= 1'b1;
              target_l <= (bus.target_rate > RATE_CEIL) ? RATE_CEIL : bus.target_rate;
              step_l   <= (bus.step == 7'd0) ? 7'd1 : bus.step;
              dwell_l  <= (bus.dwell == '0) ? CNT_ONE : bus.dwell;
              hold_l   <= (bus.hold_cycles == '0) ? CNT_ONE : bus.hold_cycles;
            end
          end

          RAMP_UP: begin
            if (cnt == '0) begin
              if (sum_up >= {1'b0, target_l}) begin
                rate <= target_l;
                st   <= HOLD;
                cnt  <= hold_l - CNT_ONE;
              end else begin
                rate <= sum_up[6:0];
                cnt  <= dwell_l - CNT_ONE;
              end
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end

          HOLD: begin
            if (cnt == '0) begin
              st  <= RAMP_DOWN;
              cnt <= dwell_l - CNT_ONE;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end

          RAMP_DOWN: begin
            if (cnt == '0) begin
              rate <= rate_dn;
              if (rate_dn == 7'd0) begin
                st     <= DONE;
                done_r <= 1'b1;
                cnt    <= '0;
              end else begin
                cnt <= dwell_l - CNT_ONE;
              end
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end

          DONE: begin
            rate <= '0;
`ifdef TOGGLE_SEQ_LOOP_EN
            st     <= RAMP_UP;
            cnt    <= dwell_l - CNT_ONE;
            busy_r <= 1'b1;
`else
            st     <= IDLE;
            busy_r <= 1'b0;
`endif
          end

          default: begin
            st     <= IDLE;
            rate   <= '0;
            cnt    <= '0;
            busy_r <= 1'b0;
            pend   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.toggle_rate = rate;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.state       = st;

endmodule

// File: tb/tb_toggle_rate_sequencer.sv
// Directed bench for toggle_rate_sequencer: ramp timing, clamping, abort and async reset.
// Define TOGGLE_SEQ_LOOP_EN for both RTL and bench to exercise the looping build.
module tb_toggle_rate_sequencer;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  toggle_rate_if #(.DWELL_W(16)) bus ();

  toggle_rate_sequencer #(.DWELL_W(16), .MAX_RATE(100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int t, input int s, input int d, input int h);
    bus.target_rate = 7'(t);
    bus.step        = 7'(s);
    bus.dwell       = 16'(d);
    bus.hold_cycles = 16'(h);
    bus.start       = 1'b1;
    tick();
    bus.start       = 1'b0;
  endtask

  int seen[$];
  int done_cnt;
  int peak;

  // Record every change of toggle_rate until the profile is back in IDLE.
  task automatic run_profile(input string tag, input int budget);
    int last;
    bit finished;
    seen.delete();
    done_cnt = 0;
    peak     = 0;
    finished = 1'b0;
    last     = int'(bus.toggle_rate);
    for (int i = 0; i < budget && !finished; i++) begin
      tick();
      if (int'(bus.toggle_rate) != last) begin
        last = int'(bus.toggle_rate);
        seen.push_back(last);
      end
      if (last > peak) peak = last;
      if (bus.done) done_cnt++;
      if (done_cnt > 0 && bus.state == 3'd0) finished = 1'b1;
    end
    check({tag, "_finished"}, int'(finished), 1);
  endtask

  initial begin
    int dn;
    int exp2[6];
    n_tests = 0;
    n_fail  = 0;
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.target_rate = '0; bus.step = '0; bus.dwell = '0; bus.hold_cycles = '0;
    rst = 1'b1;
    #12;
    check("rst_state", int'(bus.state), 0);
    check("rst_rate",  int'(bus.toggle_rate), 0);
    check("rst_busy",  int'(bus.busy), 0);
    check("rst_done",  int'(bus.done), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Nominal profile: 25-step ramp, dwell 4, hold 8.
    do_start(100, 25, 4, 8);
    check("s1_idle_at_e0", int'(bus.state), 0);
    check("s1_busy_at_e0", int'(bus.busy), 0);
    dn = 0;
    for (int e = 1; e <= 42; e++) begin
      tick();
      if (bus.done) dn++;
      case (e)
        1:  begin check("s1_rampup_e1", int'(bus.state), 1);
                  check("s1_busy_e1", int'(bus.busy), 1); end
        4:  check("s1_rate_e4", int'(bus.toggle_rate), 0);
        5:  check("s1_rate_e5", int'(bus.toggle_rate), 25);
        9:  check("s1_rate_e9", int'(bus.toggle_rate), 50);
        13: check("s1_rate_e13", int'(bus.toggle_rate), 75);
        16: check("s1_state_e16", int'(bus.state), 1);
        17: begin check("s1_rate_e17", int'(bus.toggle_rate), 100);
                  check("s1_hold_e17", int'(bus.state), 2); end
        24: check("s1_hold_e24", int'(bus.state), 2);
        25: begin check("s1_down_e25", int'(bus.state), 3);
                  check("s1_rate_e25", int'(bus.toggle_rate), 100); end
        29: check("s1_rate_e29", int'(bus.toggle_rate), 75);
        37: check("s1_rate_e37", int'(bus.toggle_rate), 25);
        41: begin check("s1_rate_e41", int'(bus.toggle_rate), 0);
                  check("s1_done_state_e41", int'(bus.state), 4);
                  check("s1_done_e41", int'(bus.done), 1); end
`ifndef TOGGLE_SEQ_LOOP_EN
        42: begin check("s1_idle_e42", int'(bus.state), 0);
                  check("s1_done_e42", int'(bus.done), 0);
                  check("s1_busy_e42", int'(bus.busy), 0); end
`endif
        default: ;
      endcase
    end
    check("s1_done_pulses", dn, 1);

`ifndef TOGGLE_SEQ_LOOP_EN
    // Clamped final up-step; config changes after the start edge must not matter.
    do_start(90, 40, 2, 3);
    bus.target_rate = 7'd10;
    bus.step        = 7'd3;
    run_profile("s2", 200);
    exp2 = '{40, 80, 90, 50, 10, 0};
    check("s2_len", seen.size(), 6);
    for (int i = 0; i < 6 && i < seen.size(); i++)
      check($sformatf("s2_rate%0d", i), seen[i], exp2[i]);
    check("s2_peak", peak, 90);
    check("s2_done_cnt", done_cnt, 1);

    // Zero target: rate never moves, profile still completes.
    do_start(0, 5, 1, 1);
    run_profile("s_zero", 100);
    check("s_zero_changes", seen.size(), 0);
    check("s_zero_done_cnt", done_cnt, 1);
`endif

    // Ceiling and minimum clamps: target 120 -> 100, step/dwell/hold 0 -> 1.
    do_start(120, 0, 0, 0);
    for (int e = 1; e <= 103; e++) begin
      tick();
      case (e)
        1:   check("s3_rate_e1", int'(bus.toggle_rate), 0);
        2:   check("s3_rate_e2", int'(bus.toggle_rate), 1);
        51:  check("s3_rate_e51", int'(bus.toggle_rate), 50);
        100: check("s3_rate_e100", int'(bus.toggle_rate), 99);
        101: begin check("s3_rate_e101", int'(bus.toggle_rate), 100);
                   check("s3_hold_e101", int'(bus.state), 2); end
        102: check("s3_down_e102", int'(bus.state), 3);
        103: check("s3_rate_e103", int'(bus.toggle_rate), 99);
        default: ;
      endcase
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("s3_abort_idle", int'(bus.state), 0);

    // Abort with start in HOLD: abort wins, no done, start not latched.
    do_start(100, 25, 4, 8);
    for (int e = 1; e <= 20; e++) tick();
    check("s4_in_hold", int'(bus.state), 2);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    tick();
    check("s4_state", int'(bus.state), 0);
    check("s4_rate",  int'(bus.toggle_rate), 0);
    check("s4_done",  int'(bus.done), 0);
    check("s4_busy",  int'(bus.busy), 0);
    bus.abort = 1'b0;
    bus.start = 1'b0;
    dn = 0;
    for (int e = 0; e < 4; e++) begin
      tick();
      if (bus.state != 3'd0 || bus.done) dn++;
    end
    check("s4_stays_idle", dn, 0);

    // Asynchronous reset between edges during RAMP_UP.
    do_start(100, 25, 4, 8);
    for (int e = 1; e <= 7; e++) tick();
    check("s5_pre_rate", int'(bus.toggle_rate), 25);
    #2;
    rst = 1'b1;
    #1;
    check("s5_async_state", int'(bus.state), 0);
    check("s5_async_rate",  int'(bus.toggle_rate), 0);
    check("s5_async_busy",  int'(bus.busy), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int e = 0; e < 5; e++) tick();
    check("s5_wait_idle", int'(bus.state), 0);
    check("s5_wait_rate", int'(bus.toggle_rate), 0);

`ifdef TOGGLE_SEQ_LOOP_EN
    // Looping build: three completed profiles with busy held high, then abort.
    do_start(20, 10, 1, 1);
    tick();
    dn = 0;
    begin
      int busy_drop;
      busy_drop = 0;
      for (int i = 0; i < 100 && dn < 3; i++) begin
        tick();
        if (bus.done) dn++;
        if (!bus.busy) busy_drop++;
      end
      check("loop_done_pulses", dn, 3);
      check("loop_busy_drops", busy_drop, 0);
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("loop_abort_state", int'(bus.state), 0);
    check("loop_abort_busy", int'(bus.busy), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
